// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus bundle: i_cache request/response, redirect and if_id handoff.
//   master : the fetch stage (drives icache_req/addr and id_*)
//   slave  : the environment (i_cache, branch unit, if_id)
interface if_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              icache_req;
  logic [ADDR_W-1:0] icache_addr;
  logic              icache_ready;
  logic              icache_valid;
  logic [INST_W-1:0] icache_inst;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              id_ready;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;

  modport master (
    output icache_req, icache_addr, id_valid, id_pc, id_inst,
    input  icache_ready, icache_valid, icache_inst, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  icache_req, icache_addr, id_valid, id_pc, id_inst,
    output icache_ready, icache_valid, icache_inst, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue.
// Owns the fetch PC, keeps one i_cache request outstanding at a time, buffers
// returned instructions and hands them to if_id with valid/ready.
// A redirect flushes the queue and discards any response still in flight.
// Ports:
//   clk, rst_n : clock (rising edge), async active-low reset
//   bus        : if_fetch_queue_if.master (icache_*, redirect_*, id_*)
module if_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  if_fetch_queue_if.master  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, req_pc;
  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic              id_vld, accept, push, pop, redirect;

  assign redirect = bus.redirect_valid;
  assign id_vld   = (count != '0);
  assign head     = mem[rd_ptr];

  // rst_n gates req so it drops the instant reset is asserted.
  assign bus.icache_req  = (state == ST_FETCH) && (count < CW'(DEPTH)) && rst_n;
  assign bus.icache_addr = fetch_pc;
  assign bus.id_valid    = id_vld;
  assign bus.id_pc       = id_vld ? head.pc   : '0;
  assign bus.id_inst     = id_vld ? head.inst : '0;

  assign accept = bus.icache_req && bus.icache_ready;
  // WAIT is only entered with a free slot and the queue cannot grow while
  // waiting, so a push can never hit a full queue.
  assign push   = (state == ST_WAIT) && bus.icache_valid && !redirect;
  assign pop    = id_vld && bus.id_ready && !redirect;

  // A redirect turns any request that is (or becomes) outstanding into DROP;
  // a response arriving in the redirect cycle completes it either way.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: if (accept) state_nxt = redirect ? ST_DROP : ST_WAIT;
      ST_WAIT:  if (bus.icache_valid) state_nxt = ST_FETCH;
                else if (redirect)    state_nxt = ST_DROP;
      ST_DROP:  if (bus.icache_valid) state_nxt = ST_FETCH;
      default:  state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_FETCH;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) req_pc <= fetch_pc;
      if (redirect) begin
        fetch_pc <= bus.redirect_pc;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        if (push)   wr_ptr   <= wr_ptr + 1'b1;
        if (pop)    rd_ptr   <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: req_pc, inst: bus.icache_inst};
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_fetch_queue_if #(.ADDR_W(32), .INST_W(32)) bus ();

  if_fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // scoreboard: instructions expected on id_*, in order
  ent_t sb[$];
  int   nvec = 0;
  int   nfail = 0;

  // reference i_cache / fetch model
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] out_pc;
  bit          busy = 0;   // a request is outstanding
  bit          keep = 0;   // its response is still wanted (no redirect since accept)
  int          cd = 0;
  int          p_ready = 100, p_idr = 100, p_redir = 0, max_d = 1;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  // One clock cycle: check state-derived outputs against the model, then
  // drive this cycle's inputs and advance the model.
  task automatic step();
    bit          exp_req, resp, rdy, rdr, acc;
    logic [31:0] inst, rpc;
    @(posedge clk); #1;
    exp_req = !busy && (sb.size() < DEPTH);
    chk("id_valid", 32'(bus.id_valid), 32'(sb.size() != 0));
    chk("icache_req", 32'(bus.icache_req), 32'(exp_req));
    if (exp_req) chk("icache_addr", bus.icache_addr, exp_pc);
    if (sb.size() == 0) begin
      chk("id_pc_empty", bus.id_pc, 32'h0);
      chk("id_inst_empty", bus.id_inst, 32'h0);
    end
    resp = 0;
    if (busy) begin
      cd--;
      resp = (cd == 0);
    end
    rdy = ($urandom_range(0, 99) < p_ready);
    rdr = ($urandom_range(0, 99) < (resp ? 3 * p_redir : p_redir));
    acc = exp_req && rdy;
    inst = $urandom;
    rpc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
    bus.icache_ready   = rdy;
    bus.id_ready       = ($urandom_range(0, 99) < p_idr);
    bus.icache_valid   = resp;
    bus.icache_inst    = inst;
    bus.redirect_valid = rdr;
    bus.redirect_pc    = rpc;
    if (resp) begin
      if (keep && !rdr) sb.push_back('{pc: out_pc, inst: inst});
      busy = 0;
    end
    if (acc) begin
      busy   = 1;
      keep   = 1;
      out_pc = exp_pc;
      cd     = $urandom_range(1, max_d);
      exp_pc = exp_pc + 32'd4;
    end
    if (rdr) begin
      exp_pc = rpc;
      keep   = 0;
      sb.delete();
    end
  endtask

  task automatic idle_inputs();
    bus.icache_ready   = 1'b0;
    bus.icache_valid   = 1'b0;
    bus.icache_inst    = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_req"},   32'(bus.icache_req), 32'h0);
    chk({tag, "_addr"},  bus.icache_addr, 32'h0);
    chk({tag, "_valid"}, 32'(bus.id_valid), 32'h0);
    chk({tag, "_pc"},    bus.id_pc, 32'h0);
    chk({tag, "_inst"},  bus.id_inst, 32'h0);
  endtask

  task automatic run(int n, int rdy, int idr, int rdr, int d);
    p_ready = rdy; p_idr = idr; p_redir = rdr; max_d = d;
    repeat (n) step();
  endtask

  // monitor: every handshake on id_* must match the scoreboard head
  always @(negedge clk) begin
    ent_t e;
    if (rst_n && bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
      if (sb.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL pop_unexpected got pc %h want no entry", bus.id_pc);
      end else begin
        e = sb.pop_front();
        chk("pop_pc", bus.id_pc, e.pc);
        chk("pop_inst", bus.id_inst, e.inst);
      end
    end
  end

  initial begin
    int guard;
    idle_inputs();
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // straight-line fetch, one-cycle i_cache, no stalls
    run(30, 100, 100, 0, 1);
    // if_id stalls: queue fills to DEPTH, then drains and fetch resumes
    run(20, 100, 0, 0, 1);
    run(20, 100, 100, 0, 1);
    // i_cache back-pressure: request must hold address until accepted
    run(15, 0, 100, 0, 1);
    run(20, 100, 100, 0, 1);
    // random mix with redirects
    run(300, 60, 60, 5, 3);

    // reset pulse while a request is outstanding
    guard = 0;
    p_ready = 100; p_redir = 0; max_d = 3;
    while (!busy && guard < 50) begin step(); guard++; end
    chk("busy_before_reset", 32'(busy), 32'h1);
    @(posedge clk); #1;
    idle_inputs();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    sb.delete();
    busy = 0; keep = 0; exp_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run(20, 100, 100, 0, 1);
    run(200, 50, 70, 10, 3);

    // drain: stop issuing, let everything outstanding land and pop out
    run(25, 0, 100, 0, 3);
    chk("drain_sb_empty", 32'(sb.size()), 32'h0);
    chk("drain_id_valid", 32'(bus.id_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
